// File: rtl/ddr4_pkg.sv
// Shared types and constants for the DDR4 transaction sequencer.
//   state_e    : sequencer FSM states
//   CMD_*      : A[ADDRWIDTH-1 -: 3] encodings (RAS_n/CAS_n/WE_n) for WRITE/READ/PRECHARGE
//   LFSR_POLY  : Galois mask for x^32+x^22+x^2+x+1 (right-shifting form)
//   lfsr_next  : one LFSR step
package ddr4_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_W_RCD,
        S_WR,
        S_W_WL,
        S_WDAT,
        S_W_WR,
        S_ACT2,
        S_W_RCD2,
        S_RD,
        S_W_RL,
        S_RDAT,
        S_PRE,
        S_W_RP,
        S_DONE
    } state_e;

    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_PRE = 3'b010;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/ddr4_txn_sequencer_if.sv
// DIMM command/data bus driven by the sequencer.
//   master : sequencer side (drives command, address and write data, receives dq_in)
//   slave  : DIMM side
//   cs_n/act_n/A/bg/ba : command bus; dq_out/dq_oe/dqs_t/dqs_c : write data path;
//   dq_in : read data returned by the DIMM
interface ddr4_txn_sequencer_if #(
    parameter int RANKS     = 1,
    parameter int CHIPS     = 16,
    parameter int DQWIDTH   = 64,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17
);
    logic [RANKS-1:0]     cs_n;
    logic                 act_n;
    logic [ADDRWIDTH-1:0] A;
    logic [BGWIDTH-1:0]   bg;
    logic [BAWIDTH-1:0]   ba;
    logic [DQWIDTH-1:0]   dq_out;
    logic                 dq_oe;
    logic [CHIPS-1:0]     dqs_t;
    logic [CHIPS-1:0]     dqs_c;
    logic [DQWIDTH-1:0]   dq_in;

    modport master (
        output cs_n, act_n, A, bg, ba, dq_out, dq_oe, dqs_t, dqs_c,
        input  dq_in
    );

    modport slave (
        input  cs_n, act_n, A, bg, ba, dq_out, dq_oe, dqs_t, dqs_c,
        output dq_in
    );
endinterface

// File: rtl/ddr4_lfsr32.sv
// 32-bit Galois LFSR used as data-pattern generator / checker.
//   ck_t    : clock, rising edge
//   reset_n : synchronous active-low reset (state -> 1)
//   load    : load seed (has priority over step)
//   step    : advance one step
//   seed    : value loaded on load
//   q       : current state
module ddr4_lfsr32
    import ddr4_pkg::*;
(
    input  logic        ck_t,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] q
);
    logic [31:0] q_q;

    always_ff @(posedge ck_t) begin
        if (!reset_n)  q_q <= 32'h1;
        else if (load) q_q <= seed;
        else if (step) q_q <= lfsr_next(q_q);
    end

    assign q = q_q;
endmodule

// File: rtl/ddr4_txn_sequencer.sv
// DDR4 command/data sequencer: per transaction ACT -> WRITE burst -> optional
// RowClone ACT -> READ burst -> PRECHARGE, checking read data against the
// written LFSR pattern.
//   ck_t, reset_n       : clock (rising edge) and synchronous active-low reset
//   start               : one-cycle pulse, accepted only when idle
//   cfg_*               : transaction setup, latched on the accepted start
//   busy / done         : high from start to done / one-cycle end pulse
//   err_cnt             : mismatching read beats, saturating, cleared only by reset
//   txn_cnt             : completed transactions of the current run
//   bus                 : DIMM command/data bus (master side)
module ddr4_txn_sequencer
    import ddr4_pkg::*;
#(
    parameter int RANKS     = 1,
    parameter int CHIPS     = 16,
    parameter int DQWIDTH   = 64,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BL        = 8,
    parameter int TXNWIDTH  = 8,
    parameter int TRCD      = 15,
    parameter int TCL       = 15,
    parameter int TCWL      = 11,
    parameter int TWR       = 12,
    parameter int TRP       = 15
) (
    input  logic                       ck_t,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [$clog2(RANKS):0]     cfg_rank,
    input  logic [BGWIDTH-1:0]         cfg_bg,
    input  logic [BAWIDTH-1:0]         cfg_ba,
    input  logic [ADDRWIDTH-1:0]       cfg_row,
    input  logic [ADDRWIDTH-1:0]       cfg_row2,
    input  logic [COLWIDTH-1:0]        cfg_col,
    input  logic [TXNWIDTH-1:0]        cfg_ntxn,
    input  logic                       cfg_clone,
    input  logic [31:0]                cfg_seed,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                err_cnt,
    output logic [TXNWIDTH-1:0]        txn_cnt,
    ddr4_txn_sequencer_if.master       bus
);
    localparam int RW  = $clog2(RANKS) + 1;
    localparam int REP = (DQWIDTH + 31) / 32;

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [COLWIDTH-1:0]   col_q, col_d;
    logic [TXNWIDTH-1:0]   txn_q, txn_d;
    logic [15:0]           err_q, err_d;
    logic [RW-1:0]         rank_q;
    logic [BGWIDTH-1:0]    bg_q;
    logic [BAWIDTH-1:0]    ba_q;
    logic [ADDRWIDTH-1:0]  row_q, row2_q;
    logic [TXNWIDTH-1:0]   ntxn_q;
    logic                  clone_q;

    logic                  accept, txn_end;
    logic                  wr_step, rd_step;
    logic [31:0]           seed_eff, wr_q, rd_q;
    logic [REP*32-1:0]     wr_rep, rd_rep;

    assign accept   = (state_q == S_IDLE) && start;
    assign seed_eff = (cfg_seed == '0) ? 32'h1 : cfg_seed;
    assign wr_rep   = {REP{wr_q}};
    assign rd_rep   = {REP{rd_q}};

    // Both generators advance BL steps per transaction, so loading the checker
    // only on start leaves it at each transaction's start state for its read.
    ddr4_lfsr32 u_wr_lfsr (
        .ck_t    (ck_t),
        .reset_n (reset_n),
        .load    (accept),
        .step    (wr_step),
        .seed    (seed_eff),
        .q       (wr_q)
    );

    ddr4_lfsr32 u_rd_lfsr (
        .ck_t    (ck_t),
        .reset_n (reset_n),
        .load    (accept),
        .step    (rd_step),
        .seed    (seed_eff),
        .q       (rd_q)
    );

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            txn_q   <= '0;
            err_q   <= '0;
            rank_q  <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            row_q   <= '0;
            row2_q  <= '0;
            ntxn_q  <= '0;
            clone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            txn_q   <= txn_d;
            err_q   <= err_d;
            if (accept) begin
                rank_q  <= cfg_rank;
                bg_q    <= cfg_bg;
                ba_q    <= cfg_ba;
                row_q   <= cfg_row;
                row2_q  <= cfg_row2;
                ntxn_q  <= (cfg_ntxn == '0) ? TXNWIDTH'(1) : cfg_ntxn;
                clone_q <= cfg_clone;
            end
        end
    end

    // Waits of length N-1 load N-2 and are skipped entirely when N == 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        txn_d   = txn_q;
        err_d   = err_q;
        wr_step = 1'b0;
        rd_step = 1'b0;
        txn_end = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_ACT;
                col_d   = cfg_col;
                txn_d   = '0;
            end
            S_ACT, S_ACT2: begin
                if (TRCD > 1) begin
                    state_d = (state_q == S_ACT) ? S_W_RCD : S_W_RCD2;
                    cnt_d   = 16'(TRCD - 2);
                end else begin
                    state_d = (state_q == S_ACT) ? S_WR : S_RD;
                end
            end
            S_W_RCD:  if (cnt_q == '0) state_d = S_WR; else cnt_d = cnt_q - 16'd1;
            S_W_RCD2: if (cnt_q == '0) state_d = S_RD; else cnt_d = cnt_q - 16'd1;
            S_WR: begin
                if (TCWL > 1) begin
                    state_d = S_W_WL;
                    cnt_d   = 16'(TCWL - 2);
                end else begin
                    state_d = S_WDAT;
                    cnt_d   = 16'(BL - 1);
                end
            end
            S_W_WL: begin
                if (cnt_q == '0) begin
                    state_d = S_WDAT;
                    cnt_d   = 16'(BL - 1);
                end else cnt_d = cnt_q - 16'd1;
            end
            S_WDAT: begin
                wr_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_W_WR;
                    cnt_d   = 16'(TWR - 1);
                end else cnt_d = cnt_q - 16'd1;
            end
            S_W_WR: begin
                if (cnt_q == '0) state_d = clone_q ? S_ACT2 : S_RD;
                else cnt_d = cnt_q - 16'd1;
            end
            S_RD: begin
                if (TCL > 1) begin
                    state_d = S_W_RL;
                    cnt_d   = 16'(TCL - 2);
                end else begin
                    state_d = S_RDAT;
                    cnt_d   = 16'(BL - 1);
                end
            end
            S_W_RL: begin
                if (cnt_q == '0) begin
                    state_d = S_RDAT;
                    cnt_d   = 16'(BL - 1);
                end else cnt_d = cnt_q - 16'd1;
            end
            S_RDAT: begin
                rd_step = 1'b1;
                if (bus.dq_in != rd_rep[DQWIDTH-1:0] && err_q != 16'hFFFF)
                    err_d = err_q + 16'd1;
                if (cnt_q == '0) state_d = S_PRE;
                else cnt_d = cnt_q - 16'd1;
            end
            S_PRE: begin
                if (TRP > 1) begin
                    state_d = S_W_RP;
                    cnt_d   = 16'(TRP - 2);
                end else txn_end = 1'b1;
            end
            S_W_RP:  if (cnt_q == '0) txn_end = 1'b1; else cnt_d = cnt_q - 16'd1;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (txn_end) begin
            txn_d = txn_q + TXNWIDTH'(1);
            if (txn_d == ntxn_q) begin
                state_d = S_DONE;
            end else begin
                state_d = S_ACT;
                col_d   = col_q + COLWIDTH'(BL);
            end
        end
    end

    logic                 cmd_en, cmd_act_n, cmd_oe;
    logic [ADDRWIDTH-1:0] cmd_a;
    logic [BGWIDTH-1:0]   cmd_bg;
    logic [BAWIDTH-1:0]   cmd_ba;
    logic [RANKS-1:0]     cmd_cs_n;

    always_comb begin
        cmd_en    = 1'b0;
        cmd_act_n = 1'b1;
        cmd_a     = '0;
        cmd_oe    = (state_q == S_WDAT);
        case (state_q)
            S_ACT:  begin cmd_en = 1'b1; cmd_act_n = 1'b0; cmd_a = row_q;  end
            S_ACT2: begin cmd_en = 1'b1; cmd_act_n = 1'b0; cmd_a = row2_q; end
            S_WR: begin
                cmd_en = 1'b1;
                cmd_a[ADDRWIDTH-1 -: 3]  = CMD_WR;
                cmd_a[COLWIDTH-1:0]      = col_q;
            end
            S_RD: begin
                cmd_en = 1'b1;
                cmd_a[ADDRWIDTH-1 -: 3]  = CMD_RD;
                cmd_a[COLWIDTH-1:0]      = col_q;
            end
            S_PRE: begin
                cmd_en = 1'b1;
                cmd_a[ADDRWIDTH-1 -: 3]  = CMD_PRE;
            end
            default: ;
        endcase
        cmd_bg   = cmd_en ? bg_q : '0;
        cmd_ba   = cmd_en ? ba_q : '0;
        cmd_cs_n = '1;
        for (int unsigned r = 0; r < RANKS; r++)
            if (cmd_en && rank_q == RW'(r)) cmd_cs_n[r] = 1'b0;
    end

    assign bus.cs_n   = cmd_cs_n;
    assign bus.act_n  = cmd_act_n;
    assign bus.A      = cmd_a;
    assign bus.bg     = cmd_bg;
    assign bus.ba     = cmd_ba;
    assign bus.dq_oe  = cmd_oe;
    assign bus.dq_out = cmd_oe ? wr_rep[DQWIDTH-1:0] : '0;
    assign bus.dqs_t  = cmd_oe ? '1 : '0;
    assign bus.dqs_c  = cmd_oe ? '0 : '1;

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign err_cnt = err_q;
    assign txn_cnt = txn_q;
endmodule
